// File: rtl/inverse_uart_word_rx.sv
// rtl/inverse_uart_word_rx.sv - inverted-polarity 8N1 receiver pairing bytes into 16-bit little-endian words
module inverse_uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int INVERT       = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_in,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        pair_timeout
);

  localparam int TO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);

  localparam logic             INV_BIT   = (INVERT != 0);
  localparam logic             IDLE_WIRE = ~INV_BIT;
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TO_MAX);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_armed;
  logic             r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_lo;
  logic [TO_W-1:0]  r_to_cnt;

  logic w_line;
  logic w_tick;
  logic w_start_det;
  logic w_to_exp;

  assign w_line      = r_sync2 ^ INV_BIT;
  assign w_tick      = (r_cnt == CNT_W'(1));
  assign w_start_det = (r_state == S_IDLE) && r_armed && !w_line;
  assign w_to_exp    = r_phase && (r_to_cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1      <= IDLE_WIRE;
      r_sync2      <= IDLE_WIRE;
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_phase      <= 1'b0;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_lo         <= '0;
      r_to_cnt     <= '0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      frame_err    <= 1'b0;
      pair_timeout <= 1'b0;
    end else begin
      r_sync1      <= rx_in;
      r_sync2      <= r_sync1;
      word_valid   <= 1'b0;
      frame_err    <= 1'b0;
      pair_timeout <= 1'b0;

      if (w_line) begin
        r_armed <= 1'b1;
      end

      // Expiry wins over a coincident start so that byte becomes a fresh low byte.
      if (w_to_exp) begin
        pair_timeout <= 1'b1;
        r_phase      <= 1'b0;
        r_to_cnt     <= '0;
      end else if (w_start_det) begin
        r_to_cnt <= '0;
      end else if (r_phase && (r_state == S_IDLE)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_det) begin
            r_state <= S_START;
            r_cnt   <= HALF_BIT;
          end
        end

        S_START: begin
          if (w_tick) begin
            if (!w_line) begin
              r_state   <= S_DATA;
              r_cnt     <= FULL_BIT;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_line, r_shift[7:1]};
            r_cnt   <= FULL_BIT;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            if (w_line) begin
              if (!r_phase) begin
                r_lo     <= r_shift;
                r_phase  <= 1'b1;
                r_to_cnt <= '0;
              end else begin
                word_out   <= {r_shift, r_lo};
                word_valid <= 1'b1;
                r_phase    <= 1'b0;
              end
            end else begin
              // Bad stop: drop this byte and any pending low byte, wait for idle line.
              frame_err <= 1'b1;
              r_phase   <= 1'b0;
              r_armed   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_uart_word_rx.sv
// tb/tb_inverse_uart_word_rx.sv - directed bench for inverse_uart_word_rx
module tb_inverse_uart_word_rx;

  localparam int C = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_in = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        pair_timeout;

  inverse_uart_word_rx #(
    .CLKS_PER_BIT(C),
    .INVERT(1),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_in(rx_in),
    .word_out(word_out),
    .word_valid(word_valid),
    .frame_err(frame_err),
    .pair_timeout(pair_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  int to_cnt = 0;
  int hold_viol = 0;
  int last_wv_cyc = -1;
  int t_start = 0;
  logic [15:0] prev_word = '0;
  logic        prev_rst = 1'b0;

  always @(negedge clk) begin
    if (reset_n && prev_rst && (word_out !== prev_word) && !word_valid) hold_viol++;
    if (word_valid) begin
      wv_cnt++;
      last_wv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (pair_timeout) to_cnt++;
    prev_word = word_out;
    prev_rst  = reset_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // l is the logical line level; the wire carries its inverse
  task automatic drive_line(input logic l, input int n);
    rx_in = ~l;
    tick(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    t_start = cyc;
    drive_line(1'b0, C);
    for (int i = 0; i < 8; i++) drive_line(b[i], C);
    drive_line(good_stop, C);
    if (!good_stop) drive_line(1'b1, 2 * C);
  endtask

  task automatic clear_counts();
    wv_cnt = 0;
    fe_cnt = 0;
    to_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int t_hi;
    reset_n = 1'b0;
    rx_in   = 1'b0;
    tick(5);
    check("rst_word_out", 32'(word_out), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_pair_timeout", 32'(pair_timeout), 32'h0);

    reset_n = 1'b1;
    drive_line(1'b1, 4);

    clear_counts();
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    tick(5);
    check("t1_word", 32'(word_out), 32'h1234);
    check("t1_wv_cnt", 32'(wv_cnt), 32'd1);
    check("t1_fe_cnt", 32'(fe_cnt), 32'd0);
    check("t1_to_cnt", 32'(to_cnt), 32'd0);
    drive_line(1'b1, 50);
    check("t1_word_held", 32'(word_out), 32'h1234);

    clear_counts();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    t_hi = t_start;
    tick(2);
    check("t2_word_a", 32'(word_out), 32'h5AA5);
    check("t2_latency_a", 32'(last_wv_cyc), 32'(t_hi + 155));
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    t_hi = t_start;
    tick(2);
    check("t2_word_b", 32'(word_out), 32'h00FF);
    check("t2_latency_b", 32'(last_wv_cyc), 32'(t_hi + 155));
    check("t2_wv_cnt", 32'(wv_cnt), 32'd2);

    clear_counts();
    send_byte(8'h34, 1'b1);
    drive_line(1'b1, 400);
    send_byte(8'h12, 1'b1);
    send_byte(8'h56, 1'b1);
    tick(5);
    check("t3_to_cnt", 32'(to_cnt), 32'd1);
    check("t3_wv_cnt", 32'(wv_cnt), 32'd1);
    check("t3_word", 32'(word_out), 32'h5612);

    clear_counts();
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    send_byte(8'h9A, 1'b1);
    tick(5);
    check("t4_fe_cnt", 32'(fe_cnt), 32'd1);
    check("t4_to_cnt", 32'(to_cnt), 32'd0);
    check("t4_wv_cnt", 32'(wv_cnt), 32'd1);
    check("t4_word", 32'(word_out), 32'h9A78);

    clear_counts();
    drive_line(1'b0, 4);
    drive_line(1'b1, 100);
    check("t5_wv_cnt", 32'(wv_cnt), 32'd0);
    check("t5_fe_cnt", 32'(fe_cnt), 32'd0);
    check("t5_to_cnt", 32'(to_cnt), 32'd0);
    check("t5_word", 32'(word_out), 32'h9A78);

    rx_in   = 1'b1;
    reset_n = 1'b0;
    tick(3);
    check("t6_rst_word", 32'(word_out), 32'h0);
    reset_n = 1'b1;
    clear_counts();
    drive_line(1'b0, 300);
    check("t6_held_wv_cnt", 32'(wv_cnt), 32'd0);
    drive_line(1'b1, 2 * C);
    clear_counts();
    send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1);
    tick(5);
    check("t6_word", 32'(word_out), 32'hABCD);
    check("t6_wv_cnt", 32'(wv_cnt), 32'd1);

    send_byte(8'h11, 1'b1);
    drive_line(1'b0, C);
    drive_line(1'b0, C);
    drive_line(1'b1, C / 2);
    reset_n = 1'b0;
    tick(1);
    check("t7_rst_word", 32'(word_out), 32'h0);
    check("t7_rst_wv", 32'(word_valid), 32'h0);
    check("t7_rst_fe", 32'(frame_err), 32'h0);
    check("t7_rst_to", 32'(pair_timeout), 32'h0);
    rx_in = 1'b0;
    tick(5);
    reset_n = 1'b1;
    drive_line(1'b1, 10);
    clear_counts();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    tick(5);
    check("t7_word", 32'(word_out), 32'h5678);
    check("t7_wv_cnt", 32'(wv_cnt), 32'd1);
    check("t7_to_cnt", 32'(to_cnt), 32'd0);

    check("word_out_held_between_words", 32'(hold_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
